// File: rtl/crc_stream.sv
// Multi-channel streaming CRC: one data word folded per cycle into a per-channel LFSR,
// with a single-entry result register carrying the final CRC and an expected-value match.
module crc_stream #(
  parameter int               DATA_W  = 24,
  parameter int               CRC_W   = 8,
  parameter logic [CRC_W-1:0] POLY    = CRC_W'(8'h2F),
  parameter logic [CRC_W-1:0] INIT    = '1,
  parameter logic [CRC_W-1:0] XOR_OUT = '0,
  parameter int               NCH     = 4,
  parameter int               CH_W    = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  input  logic [CH_W-1:0]   s_chan,
  input  logic              s_sof,
  input  logic              s_eof,
  input  logic [CRC_W-1:0]  s_exp,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [CRC_W-1:0]  m_crc,
  output logic [CH_W-1:0]   m_chan,
  output logic              m_ok,
  output logic              err_sof
);

  // Non-reflected shift-left fold, MSB of the word first.
  function automatic logic [CRC_W-1:0] crc_fold(input logic [CRC_W-1:0] seed,
                                                input logic [DATA_W-1:0] data);
    logic [CRC_W-1:0] c;
    logic             fb;
    c = seed;
    for (int i = DATA_W - 1; i >= 0; i--) begin
      fb = c[CRC_W-1] ^ data[i];
      c  = (c << 1) ^ (fb ? POLY : '0);
    end
    return c;
  endfunction

  logic [CRC_W-1:0] lfsr_reg  [NCH];
  logic             frame_reg [NCH];

  logic [NCH-1:0]   chan_sel;
  logic             chan_hit;
  logic [CRC_W-1:0] cur_lfsr;
  logic             cur_frame;
  logic [CRC_W-1:0] seed;
  logic [CRC_W-1:0] crc_next;
  logic [CRC_W-1:0] crc_final;
  logic             accept;
  logic             beat_go;

  logic             m_valid_reg;
  logic [CRC_W-1:0] m_crc_reg;
  logic [CH_W-1:0]  m_chan_reg;
  logic             m_ok_reg;
  logic             err_sof_reg;

  assign s_ready = !m_valid_reg || m_ready;
  assign accept  = s_valid && s_ready;

  // Channel decode; an out-of-range channel matches nothing, so the beat is dropped.
  always_comb begin
    chan_sel  = '0;
    cur_lfsr  = INIT;
    cur_frame = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      if (s_chan == CH_W'(i)) begin
        chan_sel[i] = 1'b1;
        cur_lfsr    = lfsr_reg[i];
        cur_frame   = frame_reg[i];
      end
    end
  end

  assign chan_hit  = |chan_sel;
  assign beat_go   = accept && chan_hit;
  assign seed      = (s_sof || !cur_frame) ? INIT : cur_lfsr;
  assign crc_next  = crc_fold(seed, s_data);
  assign crc_final = crc_next ^ XOR_OUT;

  generate
    for (genvar gi = 0; gi < NCH; gi++) begin : g_chan
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          lfsr_reg[gi]  <= INIT;
          frame_reg[gi] <= 1'b0;
        end else if (beat_go && chan_sel[gi]) begin
          if (s_eof) begin
            lfsr_reg[gi]  <= INIT;
            frame_reg[gi] <= 1'b0;
          end else begin
            lfsr_reg[gi]  <= crc_next;
            frame_reg[gi] <= 1'b1;
          end
        end
      end
    end
  endgenerate

  // A new result may replace the one being consumed in the same cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      m_valid_reg <= 1'b0;
      m_crc_reg   <= '0;
      m_chan_reg  <= '0;
      m_ok_reg    <= 1'b0;
      err_sof_reg <= 1'b0;
    end else begin
      err_sof_reg <= beat_go && s_sof && cur_frame;
      if (beat_go && s_eof) begin
        m_valid_reg <= 1'b1;
        m_crc_reg   <= crc_final;
        m_chan_reg  <= s_chan;
        m_ok_reg    <= (crc_final == s_exp);
      end else if (m_ready) begin
        m_valid_reg <= 1'b0;
      end
    end
  end

  assign m_valid = m_valid_reg;
  assign m_crc   = m_crc_reg;
  assign m_chan  = m_chan_reg;
  assign m_ok    = m_ok_reg;
  assign err_sof = err_sof_reg;

endmodule

// File: tb/tb_crc_stream.sv
// Bench for crc_stream: vector table, hand-built corner sequences, and a random
// interleaved stream scored against a polynomial long-division CRC model.
module tb_crc_stream;

  localparam int         NCH    = 3;
  localparam logic [7:0] POLY_C = 8'h2F;
  localparam logic [7:0] INIT_C = 8'hFF;
  localparam logic [7:0] XOR_C  = 8'hFF;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       s_valid = 1'b0;
  logic       s_ready;
  logic [7:0] s_data = '0;
  logic [1:0] s_chan = '0;
  logic       s_sof = 1'b0;
  logic       s_eof = 1'b0;
  logic [7:0] s_exp = '0;
  logic       m_valid;
  logic       m_ready = 1'b1;
  logic [7:0] m_crc;
  logic [1:0] m_chan;
  logic       m_ok;
  logic       err_sof;

  crc_stream #(
    .DATA_W (8),
    .CRC_W  (8),
    .POLY   (POLY_C),
    .INIT   (INIT_C),
    .XOR_OUT(XOR_C),
    .NCH    (NCH)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .s_valid(s_valid),
    .s_ready(s_ready),
    .s_data (s_data),
    .s_chan (s_chan),
    .s_sof  (s_sof),
    .s_eof  (s_eof),
    .s_exp  (s_exp),
    .m_valid(m_valid),
    .m_ready(m_ready),
    .m_crc  (m_crc),
    .m_chan (m_chan),
    .m_ok   (m_ok),
    .err_sof(err_sof)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] crc;
    logic [1:0] chan;
    logic       ok;
  } res_t;

  typedef struct {
    logic [1:0] chan;
    int         len;
    logic [7:0] bytes [9];
    logic [7:0] exp;
    logic [7:0] crc;
    logic       ok;
    logic       drop;
  } vec_t;

  res_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   res_cnt = 0;
  int   err_seen = 0;

  logic [7:0] digits [9] = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference: remainder of (message with INIT folded into its head) * x^8 modulo G.
  function automatic logic [7:0] crc_ref(input logic [7:0] msg[$]);
    bit         b[$];
    logic [8:0] g;
    logic [7:0] init_v;
    logic [7:0] r;
    g      = {1'b1, POLY_C};
    init_v = INIT_C;
    foreach (msg[k])
      for (int j = 7; j >= 0; j--) b.push_back(msg[k][j]);
    for (int j = 0; j < 8; j++) b[j] = b[j] ^ init_v[7-j];
    for (int j = 0; j < 8; j++) b.push_back(1'b0);
    for (int i = 0; i + 8 < b.size(); i++)
      if (b[i])
        for (int j = 0; j <= 8; j++) b[i+j] = b[i+j] ^ g[8-j];
    for (int j = 0; j < 8; j++) r[7-j] = b[b.size() - 8 + j];
    return r ^ XOR_C;
  endfunction

  // Output monitor, sampling mid-cycle.
  logic       held_v = 1'b0;
  logic [7:0] held_crc;
  logic [1:0] held_chan;
  logic       held_ok;
  res_t       mon_e;

  always @(negedge clk) begin
    if (err_sof) err_seen++;
    if (m_valid && held_v) begin
      chk("stable_crc", 32'(m_crc), 32'(held_crc));
      chk("stable_chan", 32'(m_chan), 32'(held_chan));
      chk("stable_ok", 32'(m_ok), 32'(held_ok));
    end
    if (m_valid && m_ready) begin
      res_cnt++;
      $display("result ch=%0d crc=%02h ok=%0b t=%0t", m_chan, m_crc, m_ok, $time);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: got crc=%02h ch=%0d, expected no result", m_crc, m_chan);
      end else begin
        mon_e = exp_q.pop_front();
        chk("m_crc", 32'(m_crc), 32'(mon_e.crc));
        chk("m_chan", 32'(m_chan), 32'(mon_e.chan));
        chk("m_ok", 32'(m_ok), 32'(mon_e.ok));
      end
      held_v = 1'b0;
    end else if (m_valid) begin
      held_v    = 1'b1;
      held_crc  = m_crc;
      held_chan = m_chan;
      held_ok   = m_ok;
    end else begin
      held_v = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called just after a rising edge; returns just after the edge that accepted the beat.
  // mr_mode: 0/1 hold m_ready at that value, 2 randomise it every cycle.
  task automatic send_beat(input logic [1:0] ch, input logic [7:0] d, input logic sof,
                           input logic eof, input logic [7:0] ex, input int mr_mode);
    int n;
    n       = 0;
    s_valid = 1'b1;
    s_chan  = ch;
    s_data  = d;
    s_sof   = sof;
    s_eof   = eof;
    s_exp   = ex;
    forever begin
      if (mr_mode == 2) m_ready = ($urandom_range(0, 3) != 0);
      else              m_ready = mr_mode[0];
      @(negedge clk);
      if (s_ready) break;
      n++;
      if (n >= 50) begin
        checks++;
        errors++;
        $display("FAIL accept_timeout: got s_ready=0 for %0d cycles, expected acceptance", n);
        break;
      end
      tick();
    end
    tick();
    s_valid = 1'b0;
    s_sof   = 1'b0;
    s_eof   = 1'b0;
  endtask

  task automatic drain();
    int n;
    n       = 0;
    m_ready = 1'b1;
    while (exp_q.size() != 0 && n < 40) begin
      tick();
      n++;
    end
    repeat (2) tick();
    chk("results_drained", 32'(exp_q.size()), 32'd0);
  endtask

  vec_t       vecs [5];
  logic [7:0] q[$];
  logic [7:0] mmsg [NCH][256];
  int         mlen [NCH];
  logic       mfr  [NCH];

  initial begin
    int         err_base;
    int         res_base;
    int         exp_err;
    int         ch;
    logic [7:0] d;
    logic [7:0] ex;
    logic [7:0] c;
    logic       sof;
    logic       eof;

    // Vector table: {chan, len, bytes, s_exp, expected crc, expected ok, dropped}
    vecs[0] = '{2'd0, 9, digits, 8'hDF, 8'hDF, 1'b1, 1'b0};
    vecs[1] = '{2'd1, 1, '{default: 8'h00}, 8'h00, 8'hBD, 1'b0, 1'b0};
    vecs[2] = '{2'd2, 1, '{default: 8'h00}, 8'hBD, 8'hBD, 1'b1, 1'b0};
    vecs[3] = '{2'd0, 9, digits, 8'h00, 8'hDF, 1'b0, 1'b0};
    vecs[4] = '{2'd3, 1, '{default: 8'h00}, 8'h00, 8'h00, 1'b0, 1'b1};

    // Reset behaviour
    tick();
    repeat (3) begin
      @(negedge clk);
      chk("s_ready_in_reset", 32'(s_ready), 32'd1);
      tick();
    end
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_m_valid", 32'(m_valid), 32'd0);
    chk("rst_err_sof", 32'(err_sof), 32'd0);
    chk("rst_m_crc", 32'(m_crc), 32'd0);
    chk("rst_m_chan", 32'(m_chan), 32'd0);
    chk("rst_m_ok", 32'(m_ok), 32'd0);
    chk("rst_s_ready", 32'(s_ready), 32'd1);
    tick();

    // Table-driven frames, each checked for one-cycle result latency
    for (int v = 0; v < 5; v++) begin
      if (!vecs[v].drop) exp_q.push_back('{vecs[v].crc, vecs[v].chan, vecs[v].ok});
      for (int i = 0; i < vecs[v].len; i++)
        send_beat(vecs[v].chan, vecs[v].bytes[i], i == 0, i == vecs[v].len - 1, vecs[v].exp, 1);
      @(negedge clk);
      chk("latency_m_valid", 32'(m_valid), 32'(!vecs[v].drop));
      tick();
    end
    drain();

    // Two channels interleaved byte by byte
    exp_q.push_back('{8'hDF, 2'd1, 1'b1});
    exp_q.push_back('{8'hDF, 2'd2, 1'b1});
    for (int i = 0; i < 9; i++) begin
      send_beat(2'd1, digits[i], i == 0, i == 8, 8'hDF, 1);
      send_beat(2'd2, digits[i], i == 0, i == 8, 8'hDF, 1);
    end
    drain();

    // Backpressure: result pending, second eof beat held for 5 cycles
    exp_q.push_back('{8'hDF, 2'd0, 1'b1});
    for (int i = 0; i < 9; i++) send_beat(2'd0, digits[i], i == 0, i == 8, 8'hDF, 0);
    exp_q.push_back('{8'hBD, 2'd1, 1'b0});
    s_valid = 1'b1; s_chan = 2'd1; s_data = 8'h00; s_sof = 1'b1; s_eof = 1'b1; s_exp = 8'h00;
    m_ready = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk("stall_s_ready", 32'(s_ready), 32'd0);
      chk("stall_m_valid", 32'(m_valid), 32'd1);
      chk("stall_m_crc", 32'(m_crc), 32'hDF);
      tick();
    end
    m_ready = 1'b1;
    @(negedge clk);
    chk("release_s_ready", 32'(s_ready), 32'd1);
    tick();
    s_valid = 1'b0; s_sof = 1'b0; s_eof = 1'b0;
    @(negedge clk);
    chk("second_m_valid", 32'(m_valid), 32'd1);
    chk("second_m_crc", 32'(m_crc), 32'hBD);
    tick();
    drain();

    // sof on a channel already in a frame
    err_base = err_seen;
    exp_q.push_back('{8'hDF, 2'd2, 1'b1});
    send_beat(2'd2, digits[0], 1'b1, 1'b0, 8'h00, 1);
    send_beat(2'd2, digits[1], 1'b0, 1'b0, 8'h00, 1);
    send_beat(2'd2, digits[0], 1'b1, 1'b0, 8'h00, 1);
    @(negedge clk);
    chk("err_sof_pulse", 32'(err_sof), 32'd1);
    tick();
    for (int i = 1; i < 9; i++) send_beat(2'd2, digits[i], 1'b0, i == 8, 8'hDF, 1);
    drain();
    chk("err_sof_count", 32'(err_seen - err_base), 32'd1);

    // Reset in the middle of a frame
    res_base = res_cnt;
    for (int i = 0; i < 4; i++) send_beat(2'd0, digits[i], i == 0, 1'b0, 8'h00, 1);
    rst_n = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("midreset_s_ready", 32'(s_ready), 32'd1);
      tick();
    end
    rst_n = 1'b1;
    exp_q.push_back('{8'hDF, 2'd0, 1'b1});
    for (int i = 0; i < 9; i++) send_beat(2'd0, digits[i], i == 0, i == 8, 8'hDF, 1);
    drain();
    chk("midreset_result_count", 32'(res_cnt - res_base), 32'd1);

    // Random interleaved traffic against the division model
    err_base = err_seen;
    exp_err  = 0;
    for (int k = 0; k < NCH; k++) begin
      mlen[k] = 0;
      mfr[k]  = 1'b0;
    end
    for (int t = 0; t < 400; t++) begin
      ch  = int'($urandom_range(0, 3));
      d   = 8'($urandom);
      sof = ($urandom_range(0, 4) == 0);
      eof = ($urandom_range(0, 3) == 0);
      ex  = 8'($urandom);
      if (ch < NCH) begin
        if (sof || !mfr[ch]) begin
          if (sof && mfr[ch]) exp_err++;
          mlen[ch] = 0;
        end
        if (mlen[ch] >= 200) eof = 1'b1;
        mmsg[ch][mlen[ch]] = d;
        mlen[ch]++;
        if (eof) begin
          q.delete();
          for (int k = 0; k < mlen[ch]; k++) q.push_back(mmsg[ch][k]);
          c = crc_ref(q);
          if ($urandom_range(0, 1) == 1) ex = c;
          exp_q.push_back('{c, 2'(ch), ex == c});
          mfr[ch]  = 1'b0;
          mlen[ch] = 0;
        end else begin
          mfr[ch] = 1'b1;
        end
      end
      send_beat(2'(ch), d, sof, eof, ex, 2);
    end
    drain();
    chk("random_err_sof_count", 32'(err_seen - err_base), 32'(exp_err));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/crc_stream.md
CRC_STREAM -- requirements
Module: crc_stream

Interface
REQ-001 Parameter DATA_W, default 24: payload bits per beat, 1..64.
REQ-002 Parameter CRC_W, default 8: CRC width, 1..32.
REQ-003 Parameter POLY, default 8'h2F: generator polynomial, implicit x^CRC_W term omitted; 8'h2F = 1+x+x^2+x^3+x^5+x^8.
REQ-004 Parameter INIT, default all ones: LFSR seed at start of frame.
REQ-005 Parameter XOR_OUT, default all zeros: mask XORed into the reported CRC.
REQ-006 Parameter NCH, default 4: independent channel contexts, 1..16; CH_W = max(1, clog2(NCH)).
REQ-007 clk  in  1  sole clock, all state on rising edge.
REQ-008 rst_n  in  1  synchronous reset, active low.
REQ-009 s_valid  in  1  input beat valid.
REQ-010 s_ready  out  1  input beat accepted when s_valid and s_ready are both high.
REQ-011 s_data  in  DATA_W  payload word.
REQ-012 s_chan  in  CH_W  channel of the beat.
REQ-013 s_sof  in  1  first beat of a frame.
REQ-014 s_eof  in  1  last beat of a frame.
REQ-015 s_exp  in  CRC_W  expected CRC, sampled only on an accepted eof beat.
REQ-016 m_valid  out  1  result valid.
REQ-017 m_ready  in  1  result consumed when m_valid and m_ready are both high.
REQ-018 m_crc  out  CRC_W  final CRC, already XORed with XOR_OUT.
REQ-019 m_chan  out  CH_W  channel of the result.
REQ-020 m_ok  out  1  high when m_crc equals the sampled s_exp.
REQ-021 err_sof  out  1  one-cycle pulse: sof accepted on a channel already in FRAME.

Function
REQ-022 Each channel holds a CRC_W-bit LFSR and a state, IDLE or FRAME.
REQ-023 Per beat, the core is non-reflected and shift-left: bits are processed s_data[DATA_W-1] first; per bit, fb = lfsr[CRC_W-1] ^ bit, lfsr = (lfsr<<1) ^ (fb ? POLY : 0).
REQ-024 The whole word is folded combinationally within one cycle; no multi-cycle iteration.
REQ-025 Seed rule: an accepted beat with s_sof=1, or any accepted beat on an IDLE channel, starts from INIT; otherwise it starts from the channel's stored LFSR.
REQ-026 An accepted beat with s_eof=0 stores the new LFSR and sets the channel to FRAME.
REQ-027 An accepted beat with s_eof=1 loads the output register on the next edge and returns the channel to IDLE with LFSR=INIT; the output register holds m_crc = lfsr ^ XOR_OUT, m_chan, m_ok and m_valid=1.
REQ-028 A beat with s_sof=1 and s_eof=1 is a complete single-beat frame seeded from INIT.
REQ-029 Latency from accepted eof beat to m_valid is exactly 1 cycle.
REQ-030 The output register is a single entry; s_ready = !m_valid | m_ready, combinational.
REQ-031 All beat types stall while s_ready=0; s_valid with s_ready=0 changes no state.
REQ-032 m_valid falls on the edge where m_ready=1, unless an eof beat is accepted in the same cycle; in that case it stays high and the register reloads, so back-to-back results are possible at 1 per cycle.
REQ-033 Outputs m_crc, m_chan and m_ok are stable while m_valid=1 and m_ready=0.
REQ-034 sof on a FRAME channel discards that channel's partial CRC, restarts from INIT and pulses err_sof for 1 cycle, coincident with the update edge; other channels are unaffected.
REQ-035 A beat on channel c never modifies the context of any other channel, so beats of different channels may interleave freely.
REQ-036 s_chan >= NCH: the beat is accepted and dropped, with no state change and no result.

Reset
REQ-037 While rst_n=0 at a clock edge: m_valid=0, err_sof=0, m_crc=0, m_chan=0, m_ok=0, every channel IDLE with LFSR=INIT.
REQ-038 s_ready reads 1 during and after reset.
REQ-039 Reset mid-frame abandons all partial frames; no result is emitted for them.

Verification
REQ-040 DATA_W=8, CRC_W=8, POLY=8'h2F, INIT=8'hFF, XOR_OUT=8'hFF, channel 0, bytes 31..39 (ASCII "123456789", sof on first, eof on last), s_exp=8'hDF -> one result, m_crc=8'hDF, m_ok=1, m_chan=0.
REQ-041 Same config, single beat 8'h00 with sof and eof, s_exp=8'h00 -> m_crc=8'hBD, m_ok=0, m_valid one cycle after acceptance.
REQ-042 "123456789" split across channels 1 and 2, interleaved byte by byte -> two results, both 8'hDF, with m_chan 1 then 2.
REQ-043 m_ready held 0 for 5 cycles with a result pending and a further eof beat offered -> s_ready=0, the beat is held, the first result is stable, then the second result follows on the cycle after release.
REQ-044 Frame "12" then sof of "123456789" on the same channel without eof -> err_sof pulses once, result 8'hDF.
REQ-045 rst_n=0 after 4 bytes of a frame, then a full "123456789" frame -> exactly one result, 8'hDF.
